// File: rtl/ring_router_mux_pkg.sv
// Shared ring-router types: flit layout, arbiter states, priority codes.
// Reused by the demux, the merge arbiter and the egress register.
`timescale 1ns/1ps
package osd_ring_pkg;

  localparam int DII_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOCK_RING  = 2'd1,
    LOCK_LOCAL = 2'd2
  } arb_state_t;

  localparam logic ARB_PRIO_RING  = 1'b0;
  localparam logic ARB_PRIO_LOCAL = 1'b1;

  typedef struct packed {
    logic [DII_DATA_W-1:0] data;
    logic                  first;
    logic                  last;
  } dii_flit_t;

endpackage

// File: rtl/ring_router_mux_if.sv
// dii_channel: one flit lane with valid/ready handshake.
// master drives the flit, slave returns ready.
`timescale 1ns/1ps
interface dii_channel;
  import osd_ring_pkg::*;

  logic [DII_DATA_W-1:0] data;
  logic                  first;
  logic                  last;
  logic                  valid;
  logic                  ready;

  modport master (
    output data, first, last, valid,
    input  ready
  );

  modport slave (
    input  data, first, last, valid,
    output ready
  );

endinterface

// File: rtl/ring_router_mux_outreg.sv
// One-entry valid/ready register; full throughput since a held
// flit can be replaced in the same cycle it drains.
`timescale 1ns/1ps
module ring_router_outreg
  import osd_ring_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  dii_flit_t  in_flit_i,
  dii_channel.master out_o
);

  logic      valid_q, valid_d;
  dii_flit_t flit_q, flit_d;
  logic      acc;

  assign in_ready_o = !valid_q | out_o.ready;
  assign acc        = in_valid_i & in_ready_o;

  always_comb begin
    valid_d = valid_q;
    flit_d  = flit_q;
    if (acc) begin
      valid_d = 1'b1;
      flit_d  = in_flit_i;
    end else if (out_o.ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      flit_q  <= '0;
    end else begin
      valid_q <= valid_d;
      flit_q  <= flit_d;
    end
  end

  assign out_o.valid = valid_q;
  assign out_o.data  = flit_q.data;
  assign out_o.first = flit_q.first;
  assign out_o.last  = flit_q.last;

endmodule

// File: rtl/ring_router_mux.sv
// Worm-level round-robin merge of ring pass-through and local
// injection onto one outgoing ring link.
`timescale 1ns/1ps
module ring_router_mux
  import osd_ring_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  dii_channel.slave  in_ring,
  dii_channel.slave  in_local,
  dii_channel.master out_ring,
  output logic [1:0] dbg_state,
  output logic       dbg_prio
);

  arb_state_t state_q, state_d;
  logic       prio_q, prio_d;
  logic       gnt_ring, gnt_local;
  logic       sel_valid, up_rdy, acc;
  dii_flit_t  sel_flit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      prio_q  <= ARB_PRIO_RING;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
    end
  end

  // Worm boundaries come only from last; first is just carried.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    if (acc) begin
      if (sel_flit.last) begin
        state_d = IDLE;
        prio_d  = gnt_ring ? ARB_PRIO_LOCAL
                           : ARB_PRIO_RING;
      end else begin
        state_d = gnt_ring ? LOCK_RING
                           : LOCK_LOCAL;
      end
    end
  end

  always_comb begin
    gnt_ring  = 1'b0;
    gnt_local = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_ring.valid && in_local.valid) begin
          gnt_ring  = (prio_q == ARB_PRIO_RING);
          gnt_local = (prio_q == ARB_PRIO_LOCAL);
        end else begin
          gnt_ring  = in_ring.valid;
          gnt_local = in_local.valid;
        end
      end
      LOCK_RING:  gnt_ring  = 1'b1;
      LOCK_LOCAL: gnt_local = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    sel_flit = '0;
    if (gnt_ring) begin
      sel_flit.data  = in_ring.data;
      sel_flit.first = in_ring.first;
      sel_flit.last  = in_ring.last;
    end else if (gnt_local) begin
      sel_flit.data  = in_local.data;
      sel_flit.first = in_local.first;
      sel_flit.last  = in_local.last;
    end
  end

  assign sel_valid = (gnt_ring & in_ring.valid)
                   | (gnt_local & in_local.valid);
  assign acc       = rst & sel_valid & up_rdy;

  assign in_ring.ready  = rst & gnt_ring & up_rdy;
  assign in_local.ready = rst & gnt_local & up_rdy;

  ring_router_outreg u_outreg (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (acc),
    .in_ready_o (up_rdy),
    .in_flit_i  (sel_flit),
    .out_o      (out_ring)
  );

  assign dbg_state = state_q;
  assign dbg_prio  = prio_q;

endmodule
